// File: rtl/reg_scoreboard_if.sv
// Decode/writeback handshake bundle for the register hazard scoreboard.
// The master (decode side) presents instructions and writebacks; the slave returns issue decisions.
interface reg_scoreboard_if;
    logic       issue_valid;
    logic [1:0] s_sel;
    logic [4:0] s_idx;
    logic [1:0] t_sel;
    logic [4:0] t_idx;
    logic [1:0] d_rw;
    logic [4:0] d_idx;
    logic       is_stop;
    logic [1:0] wb_rw;
    logic [4:0] wb_rd;
    logic       issue_ok;
    logic       stall;
    logic [6:0] outstanding;
    logic       idle;
    logic       err;

    modport master (
        output issue_valid, s_sel, s_idx, t_sel, t_idx, d_rw, d_idx, is_stop, wb_rw, wb_rd,
        input  issue_ok, stall, outstanding, idle, err
    );

    modport slave (
        input  issue_valid, s_sel, s_idx, t_sel, t_idx, d_rw, d_idx, is_stop, wb_rw, wb_rd,
        output issue_ok, stall, outstanding, idle, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for 32 GPRs and 32 FPRs; stalls issue on RAW/WAW hazards,
// a full outstanding-write window, or a stop instruction while writes are still in flight.
module reg_scoreboard #(
    parameter int MAX_OUTSTANDING = 8
) (
    input logic              clk,
    input logic              rstn,
    reg_scoreboard_if.slave  sb
);
    localparam logic [1:0] SEL_GPR = 2'b01;
    localparam logic [1:0] SEL_FPR = 2'b10;
    localparam logic [6:0] CNT_MAX = 7'(MAX_OUTSTANDING);

    logic [31:0] gpend, fpend, gpend_nxt, fpend_nxt;
    logic [6:0]  cnt, cnt_nxt;
    logic        err_r;
    logic        pend_s, pend_t, pend_d, pend_wb;
    logic        dest_wr, wb_wr, inc, dec;
    logic        stall_c, issue_ok_c;

    function automatic logic pend(input logic [1:0] sel, input logic [4:0] idx,
                                  input logic [31:0] g, input logic [31:0] f);
        case (sel)
            SEL_GPR: return g[idx];
            SEL_FPR: return f[idx];
            default: return 1'b0;
        endcase
    endfunction

    // Stall terms see registered state only, so a same-cycle writeback releases nothing.
    always_comb begin
        pend_s     = pend(sb.s_sel, sb.s_idx, gpend, fpend);
        pend_t     = pend(sb.t_sel, sb.t_idx, gpend, fpend);
        pend_d     = pend(sb.d_rw, sb.d_idx, gpend, fpend);
        pend_wb    = pend(sb.wb_rw, sb.wb_rd, gpend, fpend);
        dest_wr    = (sb.d_rw == SEL_GPR) || (sb.d_rw == SEL_FPR);
        wb_wr      = (sb.wb_rw == SEL_GPR) || (sb.wb_rw == SEL_FPR);
        stall_c    = sb.issue_valid && (pend_s || pend_t || pend_d ||
                                        (dest_wr && (cnt == CNT_MAX)) ||
                                        (sb.is_stop && (cnt != 7'd0)));
        issue_ok_c = sb.issue_valid && !stall_c;
        inc        = issue_ok_c && dest_wr;
        dec        = wb_wr && pend_wb;

        gpend_nxt = gpend;
        fpend_nxt = fpend;
        if (dec) begin
            if (sb.wb_rw == SEL_GPR) gpend_nxt[sb.wb_rd] = 1'b0;
            else                     fpend_nxt[sb.wb_rd] = 1'b0;
        end
        // Set is applied after clear so a forced set/clear collision leaves the bit set.
        if (inc) begin
            if (sb.d_rw == SEL_GPR) gpend_nxt[sb.d_idx] = 1'b1;
            else                    fpend_nxt[sb.d_idx] = 1'b1;
        end
        cnt_nxt = cnt + {6'd0, inc} - {6'd0, dec};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gpend <= '0;
            fpend <= '0;
            cnt   <= '0;
            err_r <= 1'b0;
        end else begin
            gpend <= gpend_nxt;
            fpend <= fpend_nxt;
            cnt   <= cnt_nxt;
            if (wb_wr && !pend_wb) err_r <= 1'b1;
        end
    end

    assign sb.stall       = stall_c;
    assign sb.issue_ok    = issue_ok_c;
    assign sb.outstanding = cnt;
    assign sb.idle        = (cnt == 7'd0);
    assign sb.err         = err_r;

    inv_cnt_matches_pend: assert property (@(posedge clk) disable iff (!rstn)
        32'(cnt) == ($countones(gpend) + $countones(fpend)));
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed test-plan sequence followed by random traffic, checked against a
// behavioural model of the pending sets kept as plain bit arrays.
module tb_reg_scoreboard;
    localparam int MAXO = 8;
    localparam logic [1:0] NONE = 2'b00, GPR = 2'b01, FPR = 2'b10;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    bit   g_ref [32];
    bit   f_ref [32];
    bit   err_ref;
    logic last_stall, last_ok;

    reg_scoreboard_if sb ();

    reg_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .sb   (sb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit ref_pend(input logic [1:0] sel, input logic [4:0] idx);
        if (sel == GPR) return g_ref[idx];
        if (sel == FPR) return f_ref[idx];
        return 1'b0;
    endfunction

    function automatic int ref_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(g_ref[i]) + int'(f_ref[i]);
        return n;
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < 32; i++) begin
            g_ref[i] = 1'b0;
            f_ref[i] = 1'b0;
        end
        err_ref = 1'b0;
    endfunction

    task automatic drive(input bit iv, input logic [1:0] ss, input logic [4:0] si,
                         input logic [1:0] ts, input logic [4:0] ti,
                         input logic [1:0] dr, input logic [4:0] di, input bit stop,
                         input logic [1:0] wr, input logic [4:0] wd);
        sb.issue_valid = iv;
        sb.s_sel = ss; sb.s_idx = si;
        sb.t_sel = ts; sb.t_idx = ti;
        sb.d_rw = dr;  sb.d_idx = di;
        sb.is_stop = stop;
        sb.wb_rw = wr; sb.wb_rd = wd;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit dest, es, eo;
        int n;
        @(negedge clk);
        n    = ref_cnt();
        dest = (sb.d_rw == GPR) || (sb.d_rw == FPR);
        es   = sb.issue_valid && (ref_pend(sb.s_sel, sb.s_idx) || ref_pend(sb.t_sel, sb.t_idx) ||
                                  ref_pend(sb.d_rw, sb.d_idx) || (dest && n == MAXO) ||
                                  (sb.is_stop && n != 0));
        eo   = sb.issue_valid && !es;
        chk("stall", sb.stall, es);
        chk("issue_ok", sb.issue_ok, eo);
        chk("outstanding", sb.outstanding, n);
        chk("idle", sb.idle, n == 0);
        chk("err", sb.err, err_ref);
        last_stall = sb.stall;
        last_ok    = sb.issue_ok;
        @(posedge clk);
        if (sb.wb_rw == GPR || sb.wb_rw == FPR) begin
            if (ref_pend(sb.wb_rw, sb.wb_rd)) begin
                if (sb.wb_rw == GPR) g_ref[sb.wb_rd] = 1'b0;
                else                 f_ref[sb.wb_rd] = 1'b0;
            end else begin
                err_ref = 1'b1;
            end
        end
        if (eo && dest) begin
            if (sb.d_rw == GPR) g_ref[sb.d_idx] = 1'b1;
            else                f_ref[sb.d_idx] = 1'b1;
        end
        #1;
    endtask

    task automatic issue_wr(input logic [1:0] dr, input logic [4:0] di);
        drive(1, NONE, 0, NONE, 0, dr, di, 0, NONE, 0);
        cycle();
    endtask

    task automatic wb_only(input logic [1:0] wr, input logic [4:0] wd);
        drive(0, NONE, 0, NONE, 0, NONE, 0, 0, wr, wd);
        cycle();
    endtask

    initial begin
        int q [$];
        int pick;
        ref_clear();
        drive(0, NONE, 0, NONE, 0, NONE, 0, 0, NONE, 0);
        #22 rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_outstanding", sb.outstanding, 0);
        chk("rst_idle", sb.idle, 1);
        chk("rst_err", sb.err, 0);
        chk("rst_stall", sb.stall, 0);
        chk("rst_issue_ok", sb.issue_ok, 0);

        // addi s=GPR3 d=GPR5, then retire it
        drive(1, GPR, 3, NONE, 0, GPR, 5, 0, NONE, 0); cycle();
        chk("addi_ok", last_ok, 1);
        chk("addi_out", sb.outstanding, 1);
        wb_only(GPR, 5);
        chk("addi_idle", sb.idle, 1);

        // RAW on GPR5 holds until the cycle after its writeback
        issue_wr(GPR, 5);
        drive(1, GPR, 5, NONE, 0, GPR, 6, 0, NONE, 0); cycle(); cycle();
        chk("raw_hold", last_stall, 1);
        drive(1, GPR, 5, NONE, 0, GPR, 6, 0, GPR, 5); cycle();
        chk("raw_wb_same_cycle", last_stall, 1);
        drive(1, GPR, 5, NONE, 0, GPR, 6, 0, NONE, 0); cycle();
        chk("raw_release", last_ok, 1);
        wb_only(GPR, 6);

        // files are independent; WAW stalls
        issue_wr(FPR, 7);
        drive(1, NONE, 0, GPR, 7, NONE, 0, 0, NONE, 0); cycle();
        chk("sep_files", last_ok, 1);
        issue_wr(FPR, 7);
        chk("waw", last_stall, 1);
        wb_only(FPR, 7);

        // outstanding limit
        for (int i = 1; i <= 8; i++) issue_wr(GPR, 5'(i));
        chk("full_out", sb.outstanding, 8);
        issue_wr(GPR, 9);
        chk("full_stall", last_stall, 1);
        drive(1, GPR, 20, NONE, 0, NONE, 0, 0, NONE, 0); cycle();
        chk("full_nodest_ok", last_ok, 1);
        drive(1, NONE, 0, NONE, 0, GPR, 9, 0, GPR, 1); cycle();
        chk("full_wb_same", last_stall, 1);
        issue_wr(GPR, 9);
        chk("full_next_ok", last_ok, 1);
        chk("full_out_kept", sb.outstanding, 8);
        for (int i = 2; i <= 9; i++) wb_only(GPR, 5'(i));

        // stop waits for in-flight writes
        issue_wr(GPR, 10);
        issue_wr(FPR, 11);
        drive(1, NONE, 0, NONE, 0, NONE, 0, 1, NONE, 0); cycle();
        chk("stop_hold", last_stall, 1);
        drive(1, NONE, 0, NONE, 0, NONE, 0, 1, GPR, 10); cycle();
        drive(1, NONE, 0, NONE, 0, NONE, 0, 1, FPR, 11); cycle();
        chk("stop_last_wb", last_stall, 1);
        drive(1, NONE, 0, NONE, 0, NONE, 0, 1, NONE, 0); cycle();
        chk("stop_ok", last_ok, 1);

        // spurious writeback sets sticky err
        wb_only(FPR, 2);
        chk("err_set", sb.err, 1);
        chk("err_out", sb.outstanding, 0);
        wb_only(NONE, 0);
        chk("err_sticky", sb.err, 1);

        // async reset with writes pending
        issue_wr(GPR, 12);
        issue_wr(GPR, 13);
        issue_wr(GPR, 14);
        drive(0, NONE, 0, NONE, 0, NONE, 0, 0, NONE, 0);
        rstn = 1'b0;
        #2;
        chk("arst_out", sb.outstanding, 0);
        chk("arst_idle", sb.idle, 1);
        chk("arst_err", sb.err, 0);
        chk("arst_stall", sb.stall, 0);
        ref_clear();
        #3 rstn = 1'b1;
        @(posedge clk); #1;

        // random traffic; writebacks only ever retire registers the model holds pending
        for (int n = 0; n < 400; n++) begin
            q.delete();
            for (int i = 0; i < 32; i++) begin
                if (g_ref[i]) q.push_back(32 + i);
                if (f_ref[i]) q.push_back(64 + i);
            end
            drive($urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 15) == 0, NONE, 0);
            if (q.size() != 0 && $urandom_range(0, 1) == 1) begin
                pick = q[$urandom_range(0, q.size() - 1)];
                sb.wb_rw = (pick >= 64) ? FPR : GPR;
                sb.wb_rd = 5'(pick % 32);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
